// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the multi-cycle MULT/MULTU/DIV/DIVU sequencer:
// ALU opcodes, mul/div op codes, iteration count and FSM state encoding.
package muldiv_ctrl_pkg;

   localparam int unsigned WORD_WIDTH    = 32;
   localparam int unsigned ALU_OP_LENGTH = 4;
   localparam int unsigned MD_ITER_COUNT = 32;

   localparam logic [ALU_OP_LENGTH-1:0] ALU_ADD = 4'h2;
   localparam logic [ALU_OP_LENGTH-1:0] ALU_SUB = 4'h6;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_FIXUP,
      ST_DONE
   } md_state_t;

endpackage

// File: rtl/muldiv_ctrl_neg64.sv
// Combinational 64-bit two's-complement negate on split 32-bit halves;
// the low-half increment carries into the high half only when low is zero.
module muldiv_ctrl_neg64 (
   input  logic [31:0] i_lo,
   input  logic [31:0] i_hi,
   output logic [31:0] o_lo,
   output logic [31:0] o_hi
);

   logic w_carry;

   assign w_carry = (i_lo == '0);
   assign o_lo    = ~i_lo + 32'd1;
   assign o_hi    = ~i_hi + {31'd0, w_carry};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mul/div sequencer owning HI/LO and time-sharing the EX ALU.
// Build option: MULDIV_SIGNED_EN enables signed MULT/DIV handling.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     startE,
   input  logic [1:0]               mdOpE,
   input  logic [WORD_WIDTH-1:0]    rsE,
   input  logic [WORD_WIDTH-1:0]    rtE,
   input  logic                     flushE,
   output logic                     aluOwnE,
   output logic [ALU_OP_LENGTH-1:0] aluOpMd,
   output logic [WORD_WIDTH-1:0]    aluSrcAMd,
   output logic [WORD_WIDTH-1:0]    aluSrcBMd,
   input  logic [WORD_WIDTH-1:0]    aluOutE,
   output logic                     stallReq,
   output logic [WORD_WIDTH-1:0]    hiOut,
   output logic [WORD_WIDTH-1:0]    loOut,
   output logic                     hiloDone
);

   md_state_t r_state, w_next;

   logic [1:0]            r_op;
   logic [WORD_WIDTH-1:0] r_rs, r_rt, r_md, r_acc_hi, r_acc_lo, r_hi, r_lo;
   logic [5:0]            r_cnt;
   logic                  r_sign_q, r_sign_r;

   logic                  w_is_div, w_signed, w_div_ok, w_carry, w_last;
   logic [WORD_WIDTH-1:0] w_abs_rs, w_abs_rt, w_mul_b, w_div_a;
   logic [WORD_WIDTH-1:0] w_neg_lo, w_neg_hi, w_neg_rem, w_neg_rem_unused;

   assign w_is_div = (r_op == MD_DIV) || (r_op == MD_DIVU);
`ifdef MULDIV_SIGNED_EN
   assign w_signed = (r_op == MD_MULT) || (r_op == MD_DIV);
`else
   assign w_signed = 1'b0;
`endif

   assign w_abs_rs = (w_signed && r_rs[31]) ? -r_rs : r_rs;
   assign w_abs_rt = (w_signed && r_rt[31]) ? -r_rt : r_rt;
   assign w_mul_b  = r_acc_lo[0] ? r_md : '0;
   // divide: {rem,quo} shifted left; bit 32 of the partial remainder is acc_hi[31]
   assign w_div_a  = {r_acc_hi[30:0], r_acc_lo[31]};
   assign w_div_ok = ({r_acc_hi[31], w_div_a} >= {1'b0, r_md});
   assign w_carry  = (aluOutE < r_acc_hi);
   assign w_last   = (r_cnt == 6'(MD_ITER_COUNT - 1));

   muldiv_ctrl_neg64 u_neg_prod (
      .i_lo (r_acc_lo),
      .i_hi (r_acc_hi),
      .o_lo (w_neg_lo),
      .o_hi (w_neg_hi)
   );

   muldiv_ctrl_neg64 u_neg_rem (
      .i_lo (r_acc_hi),
      .i_hi ('0),
      .o_lo (w_neg_rem),
      .o_hi (w_neg_rem_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      aluOwnE   = 1'b0;
      aluOpMd   = '0;
      aluSrcAMd = '0;
      aluSrcBMd = '0;
      case (r_state)
         ST_IDLE:  if (startE && !flushE) w_next = ST_PREP;
         ST_PREP:  w_next = (w_is_div && r_rt == '0) ? ST_DONE : ST_ITER;
         ST_ITER: begin
            aluOwnE = 1'b1;
            if (w_is_div) begin
               aluOpMd   = ALU_SUB;
               aluSrcAMd = w_div_a;
               aluSrcBMd = r_md;
            end else begin
               aluOpMd   = ALU_ADD;
               aluSrcAMd = r_acc_hi;
               aluSrcBMd = w_mul_b;
            end
            if (w_last) w_next = ST_FIXUP;
         end
         ST_FIXUP: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      if (flushE && r_state != ST_IDLE) w_next = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_md     <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_cnt    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (startE && !flushE) begin
                  r_op <= mdOpE;
                  r_rs <= rsE;
                  r_rt <= rtE;
               end
            end
            ST_PREP: begin
               r_cnt    <= '0;
               r_sign_q <= w_signed & (r_rs[31] ^ r_rt[31]);
               r_sign_r <= w_signed & r_rs[31];
               if (w_is_div && r_rt == '0) begin
                  r_acc_hi <= r_rs;
                  r_acc_lo <= '1;
               end else if (w_is_div) begin
                  r_acc_hi <= '0;
                  r_acc_lo <= w_abs_rs;
                  r_md     <= w_abs_rt;
               end else begin
                  r_acc_hi <= '0;
                  r_acc_lo <= w_abs_rt;
                  r_md     <= w_abs_rs;
               end
            end
            ST_ITER: begin
               r_cnt <= r_cnt + 6'd1;
               if (w_is_div) begin
                  if (w_div_ok) {r_acc_hi, r_acc_lo} <= {aluOutE, r_acc_lo[30:0], 1'b1};
                  else          {r_acc_hi, r_acc_lo} <= {w_div_a, r_acc_lo[30:0], 1'b0};
               end else begin
                  {r_acc_hi, r_acc_lo} <= {w_carry, aluOutE, r_acc_lo[31:1]};
               end
            end
            ST_FIXUP: begin
               if (w_is_div) begin
                  if (r_sign_q) r_acc_lo <= w_neg_lo;
                  if (r_sign_r) r_acc_hi <= w_neg_rem;
               end else if (r_sign_q) begin
                  r_acc_hi <= w_neg_hi;
                  r_acc_lo <= w_neg_lo;
               end
            end
            ST_DONE: begin
               if (!flushE) begin
                  r_hi <= r_acc_hi;
                  r_lo <= r_acc_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign stallReq = startE | (r_state != ST_IDLE);
   assign hiloDone = (r_state == ST_DONE) && !flushE;
   assign hiOut    = r_hi;
   assign loOut    = r_lo;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. The block owns the HI/LO registers and stalls the pipeline while an operation runs. It time-shares the existing combinational ALU: for 32 iteration cycles it drives the ALU operands and opcode to perform the shift-add or restoring-subtract step. The EX-stage operand mux selects this block's ALU drive whenever `aluOwnE` is high.

## Interface
- Parameters: none. Widths come from `WORD_WIDTH` (32) and `ALU_OP_LENGTH`.
- Ports:
  - `clk  in  1`: clock.
  - `rst_n  in  1`: reset; asynchronous, active-low.
  - `startE  in  1`: EX-stage mul/div instruction is valid.
  - `mdOpE  in  2`: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
  - `rsE, rtE  in  WORD_WIDTH`: operands.
  - `flushE  in  1`: abort any operation in flight.
  - `aluOwnE  out  1`: this block drives the ALU this cycle.
  - `aluOpMd  out  ALU_OP_LENGTH`: either `ALU_ADD` or `ALU_SUB`.
  - `aluSrcAMd, aluSrcBMd  out  WORD_WIDTH`: ALU operands.
  - `aluOutE  in  WORD_WIDTH`: ALU result, returned in the same cycle.
  - `stallReq  out  1`: freeze IF/ID/EX.
  - `hiOut, loOut  out  WORD_WIDTH`: HI/LO register contents.
  - `hiloDone  out  1`: one-cycle pulse when HI/LO are updated.

## Operation
- FSM states: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - `startE=1` → latch op, rs, rt → PREP.
  - `startE` is ignored in every other state.
- PREP:
  - Signed ops take the absolute value of both operands; unsigned ops pass them through.
  - Record the result signs: product/quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
  - Division with rt==0 → DONE, writing HI=rs (raw) and LO=32'hFFFFFFFF.
  - Otherwise clear the iteration counter (6 bits) and go to ITER.
- ITER, multiply (32 cycles):
  - ALU add: A = acc_hi, B = multiplicand gated by multiplier LSB (0 when the LSB is 0).
  - Carry = (aluOutE < A), computed locally.
  - {carry, aluOutE, acc_lo} shifted right by 1 becomes {acc_hi, acc_lo}.
- ITER, divide (32 cycles):
  - Shift {rem, quo} left by 1.
  - ALU sub: A = shifted rem, B = divisor.
  - No borrow, i.e. (33-bit shifted rem ≥ divisor; bit 32 is the bit shifted out): rem = aluOutE, quo LSB = 1.
  - Borrow: rem is restored, quo LSB = 0.
- ITER exits to FIXUP when the counter reaches 31.
- `aluOwnE=1` only in ITER. In all other states `aluOpMd`, `aluSrcAMd` and `aluSrcBMd` are 0.
- FIXUP:
  - Multiply: 64-bit negate of the product if its sign is 1.
  - Divide: negate the quotient and/or remainder per their signs.
  - Negation uses a local incrementer; the ALU is not used.
  - Next state DONE.
- DONE: write HI/LO (mult: HI=product[63:32], LO=product[31:0]; div: HI=remainder, LO=quotient), pulse `hiloDone`, → IDLE.
- `flushE` in any non-IDLE state → IDLE on the next edge. No HI/LO write, no `hiloDone`.
- `flushE` and `startE` in the same IDLE cycle: the start is dropped.

## Timing
- `stallReq = startE | (state != IDLE)`. This is combinational, so the issuing instruction is held in EX from its first cycle.
- Normal op accepted at edge 0: PREP in cycle 1, ITER in cycles 2–33, FIXUP in cycle 34, DONE in cycle 35.
- HI/LO are visible in cycle 36. `stallReq` drops in cycle 36, so the pipeline advances there.
- Divide-by-zero: PREP in cycle 1, DONE in cycle 2.
- Reset (async) values:
  - state = IDLE
  - `hiOut` = `loOut` = 0
  - `hiloDone` = 0, `stallReq` = `startE` (combinational)
  - `aluOwnE` = 0, `aluOpMd` = `aluSrcAMd` = `aluSrcBMd` = 0
- Reset mid-operation: abort, HI/LO cleared.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT/DIV are signed as described above.
- Not defined: PREP and FIXUP skip all sign handling, so MULT≡MULTU and DIV≡DIVU. Latency is unchanged, so pipeline timing is identical in both builds.

## Structure
- Shared package/header holds:
  - `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU` op codes
  - FSM state encodings
  - `MD_ITER_COUNT` = 32
  - existing `ALU_ADD`/`ALU_SUB` and `WORD_WIDTH`
- Natural sub-module: `neg64`, a combinational two's-complement negate with 32-bit low/high halves, used in FIXUP.

## Test plan
- MULTU rs=32'hFFFFFFFF, rt=32'hFFFFFFFF → cycle 36: HI=32'hFFFFFFFE, LO=32'h00000001; `hiloDone` pulse in cycle 35; `stallReq` high cycles 0–35.
- MULT rs=-3 (32'hFFFFFFFD), rt=7 → HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. Without `MULDIV_SIGNED_EN`: HI=32'h00000006, LO=32'hFFFFFFEB.
- DIV rs=-7, rt=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU rs=100, rt=7 → LO=14, HI=2.
- DIVU rs=32'h12345678, rt=0 → `hiloDone` in cycle 2, HI=32'h12345678, LO=32'hFFFFFFFF.
- Start MULTU, assert `flushE` in cycle 10 → IDLE in cycle 11, HI/LO unchanged, no `hiloDone`. `startE` pulsed during cycles 2–33 of a running op is ignored.
- Check `aluOwnE` is high in exactly 32 cycles per non-zero op, `aluOpMd` = `ALU_ADD` for mult and `ALU_SUB` for div; drop `rst_n` mid-ITER → outputs at reset values immediately.
